// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the shift sequencer and its 64-bit load/enable
// shift register partner.
package shift_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [1:0] AMT_L1 = 2'b00;
  localparam logic [1:0] AMT_L8 = 2'b01;
  localparam logic [1:0] AMT_R1 = 2'b10;
  localparam logic [1:0] AMT_R8 = 2'b11;

  localparam logic [CNT_W-1:0] STEP_BIG = CNT_W'(8);

  // Maps direction and step size onto the shift register amount encoding.
  function automatic logic [1:0] amt_code(input logic dir, input logic big);
    logic [1:0] code;
    case ({dir, big})
      2'b00:   code = AMT_L1;
      2'b01:   code = AMT_L8;
      2'b10:   code = AMT_R1;
      default: code = AMT_R8;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request and result handshakes of the shift sequencer.
// The requester/consumer uses master, the sequencer uses slave.
interface shift_sequencer_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 6
);
  import shift_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_dir;
  logic [CNT_W-1:0]  req_count;
  logic [DATA_W-1:0] req_data;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;

  modport master (
    output req_valid, req_dir, req_count, req_data,
    input  req_ready,
    input  res_valid, res_data,
    output res_ready
  );

  modport slave (
    input  req_valid, req_dir, req_count, req_data,
    output req_ready,
    output res_valid, res_data,
    input  res_ready
  );

endinterface

// File: rtl/shift_sequencer.sv
// Control stage that loads an operand into the 64-bit shift register, walks the
// requested distance in by-8 and by-1 steps, and hands back the shifted value.
module shift_sequencer #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_sequencer_if.slave  bus,
  output logic              sh_load,
  output logic              sh_ena,
  output logic [1:0]        sh_amount,
  output logic [DATA_W-1:0] sh_data,
  input  logic [DATA_W-1:0] sh_q,
  output logic              busy
);
  import shift_pkg::*;

  localparam logic [CNT_W-1:0] STEP_ONE = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              dir_q, dir_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              big_step;

  // The by-8 step is only taken while at least 8 remain, so rem never wraps.
  assign big_step = (rem_q >= STEP_BIG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          dir_d   = bus.req_dir;
          rem_d   = bus.req_count;
          data_d  = bus.req_data;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = (rem_q != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        rem_d = big_step ? (rem_q - STEP_BIG) : (rem_q - STEP_ONE);
        if (rem_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: decoded from registered state only.
  assign bus.req_ready = (state_q == IDLE);
  assign sh_load       = (state_q == LOAD);
  assign sh_ena        = (state_q == SHIFT);
  assign sh_amount     = sh_ena ? amt_code(dir_q, big_step) : AMT_L1;
  assign sh_data       = sh_load ? data_q : '0;
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = sh_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer paired with a behavioural 64-bit load/enable shift register.
module tb_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        sh_load;
  logic        sh_ena;
  logic [1:0]  sh_amount;
  logic [63:0] sh_data;
  logic [63:0] sh_q;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int overlap_cnt = 0;
  int idle_amt_cnt = 0;
  logic [1:0] steps[$];

  shift_sequencer_if #(.DATA_W(64), .CNT_W(6)) bus ();

  shift_sequencer #(.DATA_W(64), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sh_load   (sh_load),
    .sh_ena    (sh_ena),
    .sh_amount (sh_amount),
    .sh_data   (sh_data),
    .sh_q      (sh_q),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift register partner: no reset, keeps contents across sequencer resets.
  always @(posedge clk) begin
    if (sh_load)
      sh_q <= sh_data;
    else if (sh_ena)
      case (sh_amount)
        2'b00:   sh_q <= {sh_q[62:0], 1'b0};
        2'b01:   sh_q <= {sh_q[55:0], 8'h00};
        2'b10:   sh_q <= {sh_q[63], sh_q[63:1]};
        default: sh_q <= {{8{sh_q[63]}}, sh_q[63:8]};
      endcase
  end

  always @(negedge clk) begin
    if (sh_load && sh_ena) overlap_cnt <= overlap_cnt + 1;
    if (!sh_ena && sh_amount != 2'b00) idle_amt_cnt <= idle_amt_cnt + 1;
    if (sh_ena) steps.push_back(sh_amount);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_shift(input logic dir, input int cnt, input logic [63:0] d);
    logic signed [63:0] s;
    s = d;
    if (dir) return s >>> cnt;
    return d << cnt;
  endfunction

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    chk({pfx, "_busy"},      64'(busy),          64'd0);
    chk({pfx, "_sh_load"},   64'(sh_load),       64'd0);
    chk({pfx, "_sh_ena"},    64'(sh_ena),        64'd0);
    chk({pfx, "_sh_amount"}, 64'(sh_amount),     64'd0);
    chk({pfx, "_sh_data"},   sh_data,            64'd0);
    chk({pfx, "_res_valid"}, 64'(bus.res_valid), 64'd0);
  endtask

  // Drives one request at a negedge; returns just after the accepting edge.
  task automatic send(input logic dir, input int cnt, input logic [63:0] data, output bit ok);
    int w = 0;
    ok = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) begin
      chk("req_ready_timeout", 64'(bus.req_ready), 64'd1);
      return;
    end
    steps.delete();
    bus.req_valid = 1'b1;
    bus.req_dir   = dir;
    bus.req_count = 6'(cnt);
    bus.req_data  = data;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_dir   = 1'($urandom);
    bus.req_count = 6'($urandom);
    bus.req_data  = {$urandom, $urandom};
    ok = 1;
  endtask

  task automatic run(input logic dir, input int cnt, input logic [63:0] data,
                     input int hold, input bit hold_req);
    bit ok;
    bit found;
    int cyc;
    logic [63:0] exp;
    logic [63:0] held;
    logic [1:0] exp_steps[$];
    send(dir, cnt, data, ok);
    if (!ok) return;
    exp = ref_shift(dir, cnt, data);
    for (int i = 0; i < cnt / 8; i++) exp_steps.push_back({dir, 1'b1});
    for (int i = 0; i < cnt % 8; i++) exp_steps.push_back({dir, 1'b0});
    cyc = 0;
    found = 0;
    while (!found && cyc < 40) begin
      bus.res_ready = 1'($urandom);
      @(negedge clk);
      cyc++;
      if (bus.res_valid) found = 1;
    end
    if (!found) begin
      chk("res_valid_timeout", 64'(bus.res_valid), 64'd1);
      bus.res_ready = 1'b0;
      return;
    end
    bus.res_ready = (hold == 0);
    chk("latency",    64'(cyc), 64'(exp_steps.size() + 2));
    chk("res_data",   bus.res_data, exp);
    chk("done_busy",  64'(busy), 64'd1);
    chk("done_ready", 64'(bus.req_ready), 64'd0);
    chk("done_quiet", 64'({sh_load, sh_ena}), 64'd0);
    chk("step_count", 64'(steps.size()), 64'(exp_steps.size()));
    if (steps.size() == exp_steps.size())
      for (int i = 0; i < exp_steps.size(); i++)
        chk($sformatf("step%0d", i), 64'(steps[i]), 64'(exp_steps[i]));
    held = bus.res_data;
    for (int h = 0; h < hold; h++) begin
      if (hold_req) begin
        bus.req_valid = 1'b1;
        bus.req_dir   = 1'($urandom);
        bus.req_count = 6'($urandom_range(1, 63));
        bus.req_data  = {$urandom, $urandom};
      end
      @(negedge clk);
      chk("hold_valid", 64'(bus.res_valid), 64'd1);
      chk("hold_data",  bus.res_data, held);
      chk("hold_ready", 64'(bus.req_ready), 64'd0);
      if (h == hold - 1) begin
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b1;
      end
    end
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("release_valid", 64'(bus.res_valid), 64'd0);
    chk("release_ready", 64'(bus.req_ready), 64'd1);
    chk("release_busy",  64'(busy), 64'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int late_valid;
    bus.req_valid = 1'b0;
    bus.req_dir   = 1'b0;
    bus.req_count = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(1'b0, 19, 64'h1, 0, 0);
    run(1'b1, 12, 64'h8000_0000_0000_0000, 1, 0);
    run(1'b0, 63, 64'h1, 0, 0);
    run(1'b0, 0, 64'hDEAD_BEEF_0123_4567, 0, 0);
    run(1'b1, 27, 64'h7F00_1234_5678_9ABC, 5, 1);

    // Reset during the third SHIFT cycle of a count-40 request.
    send(1'b0, 40, {$urandom, $urandom}, ok);
    if (ok) begin
      repeat (4) @(negedge clk);
      chk("pre_reset_shift", 64'(sh_ena), 64'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      late_valid = 0;
      repeat (6) begin
        @(negedge clk);
        if (bus.res_valid || busy) late_valid++;
      end
      chk("abort_no_result", 64'(late_valid), 64'd0);
    end
    run(1'b1, 40, 64'h8123_4567_89AB_CDEF, 0, 0);

    for (int i = 0; i < 30; i++)
      run(1'($urandom), $urandom_range(0, 63), {$urandom, $urandom},
          $urandom_range(0, 3), 1'($urandom));

    chk("no_overlap",    64'(overlap_cnt),  64'd0);
    chk("amt_idle_zero", 64'(idle_amt_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
